// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared constants, capture FSM encoding and saturating counter helper
package dpwm_pkg;

    localparam int CNT_W_DEF = 11;

    typedef enum logic [1:0] {
        S_WAIT_RISE = 2'd0,
        S_HIGH      = 2'd1,
        S_LOW       = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync: multi-stage synchronizer with registered-previous rise/fall detect
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/dpwm_capture.sv
// dpwm_capture: measures high time, period and carrier phase of a gate signal and flags a stuck gate
module dpwm_capture
    import dpwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             ramp_zero,
    output logic [CNT_W-1:0] high_meas,
    output logic [CNT_W-1:0] period_meas,
    output logic [CNT_W-1:0] phase_meas,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_t           state;
    logic             s_pwm, rise, fall, timeout;
    logic [CNT_W-1:0] cnt, pcnt, idle, hold_high, phase_cap;
    logic [CNT_W-1:0] cnt_inc, pcnt_inc, idle_inc, phase_now;

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (pwm_in),
        .level(s_pwm),
        .rise (rise),
        .fall (fall)
    );

    // Counters are read in the edge cycle, so +1 turns "cycles since edge" into a width
    assign cnt_inc   = CNT_W'(sat_inc(32'(cnt), CNT_MAX));
    assign pcnt_inc  = CNT_W'(sat_inc(32'(pcnt), CNT_MAX));
    assign idle_inc  = CNT_W'(sat_inc(32'(idle), CNT_MAX));
    assign phase_now = ramp_zero ? '0 : pcnt_inc;
    assign timeout   = !(rise || fall) && (idle == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WAIT_RISE;
            cnt         <= '0;
            pcnt        <= '0;
            idle        <= '0;
            hold_high   <= '0;
            phase_cap   <= '0;
            high_meas   <= '0;
            period_meas <= '0;
            phase_meas  <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            cnt        <= rise ? '0 : cnt_inc;
            pcnt       <= ramp_zero ? '0 : pcnt_inc;
            idle       <= (rise || fall) ? '0 : idle_inc;
            if (rise)
                stuck <= 1'b0;
            if (timeout) begin
                stuck       <= 1'b1;
                stuck_level <= s_pwm;
                state       <= S_WAIT_RISE;
            end else begin
                case (state)
                    S_WAIT_RISE: if (rise) begin
                        phase_cap <= phase_now;
                        state     <= S_HIGH;
                    end
                    S_HIGH: if (fall) begin
                        hold_high <= cnt_inc;
                        state     <= S_LOW;
                    end
                    S_LOW: if (rise) begin
                        high_meas   <= hold_high;
                        period_meas <= cnt_inc;
                        phase_meas  <= phase_cap;
                        meas_valid  <= 1'b1;
                        phase_cap   <= phase_now;
                        state       <= S_HIGH;
                    end
                    default: state <= S_WAIT_RISE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dpwm_capture.sv
// tb_dpwm_capture: directed PWM streams checked against hand-computed capture results
`timescale 1ns/1ps
module tb_dpwm_capture;

    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic             ramp_zero = 1'b0;
    logic [CNT_W-1:0] high_meas, period_meas, phase_meas;
    logic             meas_valid, stuck, stuck_level;

    int checks = 0;
    int failures = 0;
    int n_valid = 0;
    int first_stuck;
    bit jit = 1'b0;
    int pub_h = 0, pub_p = 0, pub_ph = 0;

    typedef struct {
        int h;
        int p;
        int ph;
        int n;
        int eh;
        int ep;
        int eph;
        int nv;
    } row_t;

    row_t rows[4];

    dpwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(2000)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .ramp_zero  (ramp_zero),
        .high_meas  (high_meas),
        .period_meas(period_meas),
        .phase_meas (phase_meas),
        .meas_valid (meas_valid),
        .stuck      (stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_high"}, int'(high_meas), 0, 0);
        chk({tag, "_period"}, int'(period_meas), 0, 0);
        chk({tag, "_phase"}, int'(phase_meas), 0, 0);
        chk({tag, "_valid"}, int'(meas_valid), 0, 0);
        chk({tag, "_stuck"}, int'(stuck), 0, 0);
        chk({tag, "_stuck_level"}, int'(stuck_level), 0, 0);
    endtask

    // One clock: sample outputs at the falling edge, then drive (optionally delayed for jitter)
    task automatic cyc(input logic p, input logic rz, input int jd);
        @(negedge clk);
        if (meas_valid) begin
            n_valid++;
            chk("high_meas", int'(high_meas), jit ? pub_h - 1 : pub_h, jit ? pub_h + 1 : pub_h);
            chk("period_meas", int'(period_meas), jit ? pub_p - 1 : pub_p, jit ? pub_p + 1 : pub_p);
            if (!jit)
                chk("phase_meas", int'(phase_meas), pub_ph, pub_ph);
        end
        if (jd > 0)
            #(jd);
        pwm_in    = p;
        ramp_zero = rz;
    endtask

    // One PWM period; ramp_zero placed so the detected rise sees phase ph; eh/ep/eph are
    // what this period must report when it is published at the next rise
    task automatic run_period(input int h, input int p, input int ph, input bit en, input bit jitter,
                              input int eh, input int ep, input int eph,
                              input int rst_at = -1, input int rst_end = -1);
        for (int t = 0; t < p; t++) begin
            int jd;
            jd = 0;
            if (jitter && (t == 0 || t == h)) begin
                jd = $urandom_range(0, 8);
                if (jd >= 5)
                    jd++;
            end
            cyc(en && t < h, t == (2 - ph + p) % p, jd);
            if (t == rst_at) begin
                rst = 1'b1;
                #1;
                chk_zero("in_reset");
            end
            if (t == rst_end)
                rst = 1'b0;
        end
        pub_h  = eh;
        pub_p  = ep;
        pub_ph = eph;
    endtask

    initial begin
        rows[0] = '{h: 37, p: 100, ph: 12, n: 5, eh: 37, ep: 100, eph: 12, nv: 4};
        rows[1] = '{h: 80, p: 100, ph: 12, n: 3, eh: 80, ep: 100, eph: 12, nv: 3};
        rows[2] = '{h: 20, p: 64,  ph: 12, n: 3, eh: 20, ep: 64,  eph: 12, nv: 3};
        rows[3] = '{h: 50, p: 100, ph: 0,  n: 3, eh: 50, ep: 100, eph: 0,  nv: 3};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Low period that only places a ramp_zero ahead of the first rise
        run_period(0, 100, 12, 1'b0, 1'b0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            n_valid = 0;
            for (int k = 0; k < rows[r].n; k++)
                run_period(rows[r].h, rows[r].p, rows[r].ph, 1'b1, 1'b0,
                           rows[r].eh, rows[r].ep, rows[r].eph);
            chk("row_valid_count", n_valid, rows[r].nv, rows[r].nv);
        end

        // Gate held high: stuck must appear 2000 cycles after the detected rise
        n_valid = 0;
        first_stuck = -1;
        for (int i = 0; i <= 2500; i++) begin
            cyc(1'b1, 1'b0, 0);
            if (stuck && first_stuck < 0)
                first_stuck = i;
        end
        chk("stuck_delay", first_stuck, 2003, 2003);
        chk("stuck_level", int'(stuck_level), 1, 1);
        chk("stuck_valid_count", n_valid, 1, 1);
        chk("stuck_hold_high", int'(high_meas), 50, 50);
        chk("stuck_hold_period", int'(period_meas), 100, 100);
        chk("stuck_hold_phase", int'(phase_meas), 0, 0);

        n_valid = 0;
        run_period(0, 100, 12, 1'b0, 1'b0, 0, 0, 0);
        chk("stuck_through_fall", int'(stuck), 1, 1);
        run_period(37, 100, 12, 1'b1, 1'b0, 37, 100, 12);
        chk("stuck_clear", int'(stuck), 0, 0);
        chk("no_valid_after_stuck", n_valid, 0, 0);
        run_period(37, 100, 12, 1'b1, 1'b0, 37, 100, 12);
        chk("resume_valid_count", n_valid, 1, 1);

        // Edges placed at random points inside the clock period
        jit = 1'b1;
        n_valid = 0;
        repeat (6) run_period(37, 100, 12, 1'b1, 1'b1, 37, 100, 12);
        chk("jitter_valid_count", n_valid, 6, 6);

        // Reset during the high phase, released while the gate is low
        n_valid = 0;
        run_period(50, 100, 12, 1'b1, 1'b0, 50, 100, 12, 20, 70);
        jit = 1'b0;
        chk("pre_reset_valid_count", n_valid, 1, 1);
        n_valid = 0;
        run_period(50, 100, 12, 1'b1, 1'b0, 50, 100, 12);
        chk("post_reset_first_rise", n_valid, 0, 0);
        run_period(50, 100, 12, 1'b1, 1'b0, 50, 100, 12);
        chk("post_reset_second_rise", n_valid, 1, 1);
        chk("post_reset_high", int'(high_meas), 50, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpwm_capture.md
Name: dpwm_capture

Overview:
- Reader-side counterpart to the DPWM up-down generator: takes a gate signal back in, e.g. dpwm_s from a phase leg or a gate-driver feedback pin.
- Recovers in clk cycles:
  - high time (duty),
  - period,
  - phase of the rising edge relative to the carrier-zero strobe.
- Flags a stuck gate (no edge within TIMEOUT).
- Sits beside each FCML phase leg for closed-loop duty/angle verification and fault detection.

Parameters:
- CNT_W, 11, width of all counters and measurement outputs; matches the 11-bit duty/angle buses.
- SYNC_STAGES, 2, flip-flop stages in the pwm_in synchronizer (minimum 2).
- TIMEOUT, 2000, clk cycles without a pwm_in edge before stuck is declared; must be < 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pwm_in  in  1  gate signal under measurement; may be asynchronous to clk.
- ramp_zero  in  1  one-cycle strobe at the carrier zero point (phase reference).
- high_meas  out  CNT_W  last completed high time, in cycles.
- period_meas  out  CNT_W  last completed period, rise to rise, in cycles.
- phase_meas  out  CNT_W  cycles from the last ramp_zero to the last rising edge.
- meas_valid  out  1  one-cycle pulse when the three measurements update together.
- stuck  out  1  level; no edge for TIMEOUT cycles.
- stuck_level  out  1  synced pwm_in level when stuck was declared.

Behaviour:
- Reset (async, active-high): all outputs 0; state S_WAIT_RISE; all counters 0; synchronizer and edge register cleared to 0.
- Input conditioning:
  - pwm_in passes through SYNC_STAGES flops to give s_pwm.
  - s_prev is s_pwm delayed one cycle.
  - rise = s_pwm & ~s_prev; fall = ~s_pwm & s_prev.
  - Edge-detect latency: SYNC_STAGES+1 cycles from the pwm_in transition. The latency is identical for both edges, so measured widths are unbiased.
- Edge counter cnt: cleared to 0 on rise; otherwise increments, saturating at 2^CNT_W-1.
- Phase counter pcnt: cleared to 0 on ramp_zero; otherwise increments, saturating.
- FSM states:
  - S_WAIT_RISE: on rise, clear cnt, capture phase, go to S_HIGH. No measurement is published from a partial first period.
  - S_HIGH: on fall, hold_high <= cnt, go to S_LOW.
  - S_LOW: on rise, in the same cycle:
    - high_meas <= hold_high; period_meas <= cnt; phase_meas <= captured phase from the previous rise;
    - meas_valid pulses for 1 cycle; cnt cleared; new phase captured; go to S_HIGH.
  - All three outputs are registered; they update in the cycle after the rise cycle, with meas_valid high in that same cycle.
- Phase capture on rise: captured value = pcnt. If ramp_zero coincides with rise, captured value = 0.
- Timeout (any state):
  - Trigger: cnt since the last edge of either polarity reaches TIMEOUT. Use a separate idle counter, cleared on rise or fall.
  - Action: stuck <= 1; stuck_level <= s_pwm; state <= S_WAIT_RISE; measurement outputs hold their values.
- stuck clears at the first rise after it was set. That rise restarts the capture chain from S_WAIT_RISE, so meas_valid next pulses only after one further full period.
- Illegal edges: rise in S_HIGH and fall in S_LOW or S_WAIT_RISE cannot occur after edge detection. If the FSM encoding reaches an unused state, it returns to S_WAIT_RISE.
- Saturation: if a period exceeds 2^CNT_W-1 without timeout (TIMEOUT misconfigured), the output is clamped to 2^CNT_W-1.
- Reset mid-operation: asynchronous clear. meas_valid is never emitted for a period spanning reset.

Decomposition:
- Shared package dpwm_pkg:
  - CNT_W default constant;
  - FSM state encoding (S_WAIT_RISE=2'd0, S_HIGH=2'd1, S_LOW=2'd2);
  - saturating-increment function.
- One sub-module: edge_sync (SYNC_STAGES synchronizer plus rise/fall detect). It is reusable for fault and sync inputs elsewhere in the design.

Test Plan:
- Steady PWM, period 100 cycles, high 37; ramp_zero every 100 cycles, 12 cycles before each rise -> from the 2nd rise on, meas_valid every 100 cycles with high_meas=37, period_meas=100, phase_meas=12.
- Duty step 37->80 mid-stream -> first meas_valid after the step reports high 80 / period 100; no intermediate value.
- pwm_in held high 2500 cycles after the last rise -> stuck=1, stuck_level=1 exactly 2000 cycles after that edge was detected; outputs unchanged. Resume PWM -> stuck clears at the first rise; meas_valid on the following rise.
- ramp_zero coincident with the detected rise -> phase_meas=0 on the next meas_valid.
- rst asserted mid-high-phase, released, PWM 50/100 continues -> all outputs 0 during reset; first meas_valid on the 2nd rise after release with high_meas=50.
- Async pwm_in jitter: random phase vs clk, nominal high 37 / period 100 -> high_meas within 36..38, period_meas within 99..101.
